// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit width/limit, controller states and a digit
// validity helper used by the serial subtractor.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic bcd_digit_valid(input logic [3:0] digit);
    return digit <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// Single BCD digit subtract cell: d = a - b - bin, borrowing ten when negative.
// Only valid BCD digits are ever presented, so no range checking here.
module bcd_digit_sub (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout
);

  logic [4:0] diff;

  // A negative 5-bit difference wraps; its low nibble plus ten gives t + 10.
  always_comb begin
    diff = {1'b0, a} - {1'b0, b} - {4'b0000, bin};
    bout = diff[4];
    d    = bout ? (diff[3:0] + 4'd10) : diff[3:0];
  end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial packed-BCD subtractor (A - B), least-significant digit first,
// returning sign plus BCD magnitude; a negative raw result is re-complemented.
module bcd_serial_subtractor
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] A,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] B,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] D,
  output logic                          neg,
  output logic                          err,
  output logic [1:0]                    dbg_state
);

  // Handshake: start is accepted on a rising edge only while in IDLE or DONE;
  // done pulses for one cycle and D/neg/err then hold until the next accept.

  localparam int W     = BCD_DIGIT_W * DIGITS;
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_e           state, state_nxt;
  logic [W-1:0]     a_q, b_q, d_q;
  logic [IDX_W-1:0] idx;
  logic             borrow;
  logic             neg_q, err_q;

  logic             ops_valid;
  logic             accept;
  logic             last;
  logic [3:0]       cell_a, cell_b, cell_d;
  logic             cell_bout;

  always_comb begin
    ops_valid = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bcd_digit_valid(A[i*BCD_DIGIT_W +: BCD_DIGIT_W]) ||
          !bcd_digit_valid(B[i*BCD_DIGIT_W +: BCD_DIGIT_W]))
        ops_valid = 1'b0;
    end
  end

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (idx == LAST_IDX);

  // NEG reuses the cell to compute 0 - raw, feeding back the raw digits.
  assign cell_a = (state == NEG) ? 4'd0 : a_q[3:0];
  assign cell_b = (state == NEG) ? d_q[3:0] : b_q[3:0];

  bcd_digit_sub u_cell (
    .a    (cell_a),
    .b    (cell_b),
    .bin  (borrow),
    .d    (cell_d),
    .bout (cell_bout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start)     state_nxt = ops_valid ? SUB : DONE;
        else           state_nxt = IDLE;
      end
      SUB:  if (last)  state_nxt = cell_bout ? NEG : DONE;
      NEG:  if (last)  state_nxt = DONE;
      default:         state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == SUB) || (state == NEG);
    done      = (state == DONE);
    dbg_state = state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      d_q    <= '0;
      idx    <= '0;
      borrow <= 1'b0;
      neg_q  <= 1'b0;
      err_q  <= 1'b0;
    end else if (accept) begin
      a_q    <= A;
      b_q    <= B;
      d_q    <= '0;
      idx    <= '0;
      borrow <= 1'b0;
      neg_q  <= 1'b0;
      err_q  <= !ops_valid;
    end else if (state == SUB) begin
      // Result digits enter at the top so they land in place after DIGITS shifts.
      a_q    <= {4'd0, a_q[W-1:4]};
      b_q    <= {4'd0, b_q[W-1:4]};
      d_q    <= {cell_d, d_q[W-1:4]};
      idx    <= last ? '0 : idx + 1'b1;
      borrow <= last ? 1'b0 : cell_bout;
    end else if (state == NEG) begin
      d_q    <= {cell_d, d_q[W-1:4]};
      idx    <= last ? '0 : idx + 1'b1;
      borrow <= last ? 1'b0 : cell_bout;
      if (last) neg_q <= 1'b1;
    end
  end

  assign D   = d_q;
  assign neg = neg_q;
  assign err = err_q;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Directed bench for bcd_serial_subtractor (DIGITS=4) with a queue scoreboard
// checking result, sign, error flag and done latency.
module tb_bcd_serial_subtractor;

  localparam int DIGITS = 4;
  localparam int DW     = 4 * DIGITS;
  localparam int W      = DW + 2 + 8 + 16;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] A, B;
  logic          busy, done, neg, err;
  logic [DW-1:0] D;
  logic [1:0]    dbg_state;

  logic [W-1:0]  exp_q[$];
  int            checks = 0;
  int            fails  = 0;
  int            cyc    = 0;

  bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .done      (done),
    .D         (D),
    .neg       (neg),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // monitor: pops one expectation per done pulse
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        check("result_D",    32'(D),   32'(e[W-1 -: DW]));
        check("result_neg",  32'(neg), 32'(e[25]));
        check("result_err",  32'(err), 32'(e[24]));
        check("done_edge",   32'(cyc + 1 - int'(e[15:0])), 32'(e[23:16]));
      end
    end
  end

  // driver: call at a negedge; returns at the negedge after the accept edge
  task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] exp_d, input logic exp_neg,
                       input logic exp_err, input int lat);
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back({exp_d, exp_neg, exp_err, 8'(lat), 16'(cyc)});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL done_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bit busy_seen;
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    A = '0;
    B = '0;
    repeat (3) @(negedge clk);
    check("reset_D",    32'(D),    32'h0);
    check("reset_neg",  32'(neg),  32'h0);
    check("reset_err",  32'(err),  32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);

    // first accept right on the first edge after reset release
    rst_n = 1'b1;
    issue(16'h0917, 16'h0008, 16'h0909, 1'b0, 1'b0, DIGITS + 1);
    wait_done();
    issue(16'h0008, 16'h0009, 16'h0001, 1'b1, 1'b0, 2 * DIGITS + 1);
    wait_done();
    issue(16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0, DIGITS + 1);
    wait_done();
    issue(16'h0000, 16'h9999, 16'h9999, 1'b1, 1'b0, 2 * DIGITS + 1);
    wait_done();
    issue(16'h5000, 16'h4999, 16'h0001, 1'b0, 1'b0, DIGITS + 1);
    wait_done();
    issue(16'h9999, 16'h0000, 16'h9999, 1'b0, 1'b0, DIGITS + 1);
    wait_done();

    // invalid digit: immediate done, busy never raised
    busy_seen = 1'b0;
    issue(16'h00A0, 16'h0001, 16'h0000, 1'b0, 1'b1, 1);
    if (busy) busy_seen = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    check("err_busy_low", 32'(busy_seen), 32'h0);
    wait_done();
    issue(16'h1234, 16'h000F, 16'h0000, 1'b0, 1'b1, 1);
    wait_done();

    // start pulsed mid-operation is ignored
    issue(16'h0917, 16'h0008, 16'h0909, 1'b0, 1'b0, DIGITS + 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (10) @(negedge clk);

    // asynchronous reset mid-operation aborts without done
    issue(16'h0917, 16'h0008, 16'h0909, 1'b0, 1'b0, DIGITS + 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("abort_D",    32'(D),    32'h0);
    check("abort_neg",  32'(neg),  32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    issue(16'h0500, 16'h0250, 16'h0250, 1'b0, 1'b0, DIGITS + 1);
    wait_done();

    // back-to-back with start held through DONE
    A = 16'h0500;
    B = 16'h0250;
    start = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back({16'h0250, 1'b0, 1'b0, 8'(DIGITS + 1), 16'(cyc)});
    @(negedge clk);
    A = 16'h0001;
    B = 16'h0002;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b2b_done_seen", 32'(done), 32'h1);
    @(posedge clk);
    #1;
    exp_q.push_back({16'h0001, 1'b1, 1'b0, 8'(2 * DIGITS + 1), 16'(cyc)});
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy_after_accept", 32'(busy), 32'h1);
    wait_done();

    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
